// File: rtl/scratchpad_init_host.sv
// Scratchpad init/check host: streams a fill or read-check pass over TL-UL.
// SCRATCHPAD_INIT_CHECK_EN builds the read-check pass and data compare; without it every pass is a fill.
package scratchpad_tl_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 64;

  localparam logic [2:0] PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [7:0]       a_source;
    logic [TL_AW-1:0] a_address;
    logic [7:0]       a_mask;
    logic [TL_DW-1:0] a_data;
    logic [15:0]      a_user;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [7:0]       d_source;
    logic [0:0]       d_sink;
    logic [TL_DW-1:0] d_data;
    logic [15:0]      d_user;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;
endpackage

module scratchpad_init_host
  import scratchpad_tl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_STRIDE     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             check_i,
  input  logic [TL_AW-1:0] base_addr_i,
  input  logic [15:0]      len_i,
  input  logic [TL_DW-1:0] pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      err_cnt_o,
  output tl_h2d_t          tl_o,
  input  tl_d2h_t          tl_i
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic             check_q;
  logic [TL_AW-1:0] base_q;
  logic [15:0]      len_q, word_q, rsp_q, errcnt_q;
  logic [TL_DW-1:0] pat_q;
  logic [OW-1:0]    out_q;
  logic             err_q;
  logic             a_valid, a_fire, d_fire, rsp_err, start_ok;
  logic [7:0]       exp_src;
  logic             unused;

  assign start_ok = (state_q == IDLE) && start_i;
  assign a_valid  = (state_q == ISSUE) && (out_q < OW'(MAX_OUTSTANDING));
  assign a_fire   = a_valid && tl_i.a_ready;
  // Responses in IDLE are sunk (d_ready is constant) but never scored or counted.
  assign d_fire   = tl_i.d_valid && (state_q != IDLE);
  assign exp_src  = 8'(rsp_q % 16'(MAX_OUTSTANDING));

`ifdef SCRATCHPAD_INIT_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       check_q <= 1'b0;
    else if (start_ok) check_q <= check_i;
  end
  assign unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};
`else
  assign check_q = 1'b0;
  assign unused  = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, tl_i.d_data, check_i};
`endif

  always_comb begin
    rsp_err = tl_i.d_error || (tl_i.d_source != exp_src) ||
              (tl_i.d_opcode != (check_q ? ACCESS_ACK_DATA : ACCESS_ACK));
`ifdef SCRATCHPAD_INIT_CHECK_EN
    if (check_q && (tl_i.d_data != pat_q + TL_DW'(rsp_q))) rsp_err = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (len_i == 16'd0) ? DONE : ISSUE;
      ISSUE: if (a_fire && (word_q == len_q - 16'd1)) state_d = DRAIN;
      DRAIN: if (out_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fields derive from word_q, which only moves on a handshake, so they hold across stalls.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = check_q ? GET : PUT_FULL_DATA;
    tl_o.a_size    = 2'd3;
    tl_o.a_source  = 8'(word_q % 16'(MAX_OUTSTANDING));
    tl_o.a_address = base_q + TL_AW'(word_q) * TL_AW'(ADDR_STRIDE);
    tl_o.a_mask    = '1;
    tl_o.a_data    = pat_q + TL_DW'(word_q);
    tl_o.d_ready   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      word_q   <= '0;
      rsp_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q   <= base_addr_i;
        len_q    <= len_i;
        pat_q    <= pattern_i;
        word_q   <= '0;
        rsp_q    <= '0;
        out_q    <= '0;
        err_q    <= 1'b0;
        errcnt_q <= '0;
      end else begin
        if (a_fire) word_q <= word_q + 16'd1;
        if (d_fire) rsp_q <= rsp_q + 16'd1;
        case ({a_fire, d_fire})
          2'b10:   out_q <= out_q + OW'(1);
          2'b01:   out_q <= out_q - OW'(1);
          default: out_q <= out_q;
        endcase
        if (d_fire && rsp_err) begin
          err_q <= 1'b1;
          if (errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
        end
      end
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign err_o     = err_q;
  assign err_cnt_o = errcnt_q;
endmodule

// File: tb/tb_scratchpad_init_host.sv
// Directed bench for scratchpad_init_host with a small in-order TL-UL device model.
module tb_scratchpad_init_host;
  import scratchpad_tl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, check = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len = '0;
  logic [63:0] pat = '0;
  logic        busy, done, err;
  logic [15:0] err_cnt;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int checks = 0, fails = 0, done_cnt = 0;

  typedef struct {
    logic [7:0]  src;
    logic [2:0]  op;
    logic [63:0] data;
  } rsp_t;
  rsp_t rspq[$];

  logic [63:0] mem [logic [31:0]];
  logic [31:0] la[$];
  logic [63:0] ld[$];
  logic [2:0]  lop[$];
  logic [7:0]  lsrc[$];
  logic        a_rdy = 1'b1, d_en = 1'b1, d_vld = 1'b0;
  logic [7:0]  d_src = '0;
  logic [2:0]  d_op = '0;
  logic [63:0] d_dat = '0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  scratchpad_init_host #(.MAX_OUTSTANDING(4), .ADDR_STRIDE(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .check_i(check),
    .base_addr_i(base), .len_i(len), .pattern_i(pat),
    .busy_o(busy), .done_o(done), .err_o(err), .err_cnt_o(err_cnt),
    .tl_o(tl_o), .tl_i(tl_i)
  );

  always_comb begin
    tl_i          = '0;
    tl_i.a_ready  = a_rdy;
    tl_i.d_valid  = d_vld;
    tl_i.d_opcode = d_op;
    tl_i.d_source = d_src;
    tl_i.d_data   = d_dat;
    tl_i.d_size   = 2'd3;
  end

  always @(posedge clk) begin
    rsp_t r;
    if (done) done_cnt++;
    if (d_vld) void'(rspq.pop_front());
    if (tl_o.a_valid && a_rdy) begin
      la.push_back(tl_o.a_address);
      ld.push_back(tl_o.a_data);
      lop.push_back(tl_o.a_opcode);
      lsrc.push_back(tl_o.a_source);
      r.src = tl_o.a_source;
      if (tl_o.a_opcode == GET) begin
        r.op   = ACCESS_ACK_DATA;
        r.data = mem.exists(tl_o.a_address) ? mem[tl_o.a_address] : 64'h0;
        if (tl_o.a_address == corrupt_addr) r.data = 64'h0;
      end else begin
        r.op   = ACCESS_ACK;
        r.data = 64'h0;
        mem[tl_o.a_address] = tl_o.a_data;
      end
      rspq.push_back(r);
    end
  end

  always @(negedge clk) begin
    rsp_t h;
    d_vld = d_en && (rspq.size() != 0);
    if (d_vld) begin
      h = rspq[0];
      d_src = h.src; d_op = h.op; d_dat = h.data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    la.delete(); ld.delete(); lop.delete(); lsrc.delete();
    done_cnt = 0;
  endtask

  task automatic go(input logic c, input logic [31:0] b, input logic [15:0] l, input logic [63:0] p);
    @(negedge clk);
    start = 1'b1; check = c; base = b; len = l; pat = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_acnt(input int target, input int budget);
    int n = 0;
    while (la.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("a_count_reached", la.size(), target);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_errcnt", err_cnt, 16'h0);
    chk("rst_avalid", tl_o.a_valid, 1'b0);
    chk("rst_dready", tl_o.d_ready, 1'b1);
    rst_n = 1'b1;

    // Fill pass
    clr_log();
    go(1'b0, 32'h1000, 16'd4, 64'h10);
    chk("a_valid_issue", tl_o.a_valid, 1'b1);
    chk("a_size", tl_o.a_size, 2'd3);
    chk("a_mask", tl_o.a_mask, 8'hFF);
    chk("a_param", tl_o.a_param, 3'd0);
    chk("a_user", tl_o.a_user, 16'h0);
    run_to_done(100);
    chk("fill_count", la.size(), 4);
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      chk("fill_addr", la[k], 32'h1000 + 32'(k) * 8);
      chk("fill_data", ld[k], 64'h10 + 64'(k));
      chk("fill_op", lop[k], PUT_FULL_DATA);
      chk("fill_src", lsrc[k], 8'(k));
    end
    chk("fill_errcnt", err_cnt, 16'h0);
    chk("fill_done_cnt", done_cnt, 1);

`ifdef SCRATCHPAD_INIT_CHECK_EN
    clr_log();
    go(1'b1, 32'h1000, 16'd4, 64'h10);
    run_to_done(100);
    chk("chk_count", la.size(), 4);
    for (int k = 0; k < 4 && k < lop.size(); k++) chk("chk_op", lop[k], GET);
    chk("chk_err", err, 1'b0);
    chk("chk_errcnt", err_cnt, 16'h0);
    corrupt_addr = 32'h1010;
    clr_log();
    go(1'b1, 32'h1000, 16'd4, 64'h10);
    run_to_done(100);
    chk("corrupt_errcnt", err_cnt, 16'h1);
    chk("corrupt_err", err, 1'b1);
    corrupt_addr = 32'hFFFF_FFFF;
`else
    clr_log();
    go(1'b1, 32'h1000, 16'd4, 64'h10);
    run_to_done(100);
    chk("nochk_count", la.size(), 4);
    for (int k = 0; k < 4 && k < lop.size(); k++) chk("nochk_op", lop[k], PUT_FULL_DATA);
    chk("nochk_errcnt", err_cnt, 16'h0);
`endif

    // Outstanding limit with responses held off
    clr_log();
    d_en = 1'b0;
    go(1'b0, 32'h3000, 16'd8, 64'h100);
    repeat (20) @(negedge clk);
    chk("limit_count", la.size(), 4);
    chk("limit_avalid", tl_o.a_valid, 1'b0);
    chk("limit_busy", busy, 1'b1);
    d_en = 1'b1;
    run_to_done(200);
    chk("limit_total", la.size(), 8);
    for (int k = 4; k < 8 && k < lsrc.size(); k++) chk("limit_src", lsrc[k], 8'(k - 4));
    chk("limit_errcnt", err_cnt, 16'h0);

    // A-channel stall on word 2
    clr_log();
    go(1'b0, 32'h2000, 16'd4, 64'h55);
    wait_acnt(2, 50);
    a_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", tl_o.a_valid, 1'b1);
      chk("stall_addr", tl_o.a_address, 32'h2010);
      chk("stall_data", tl_o.a_data, 64'h57);
      chk("stall_src", tl_o.a_source, 8'd2);
    end
    chk("stall_count", la.size(), 2);
    a_rdy = 1'b1;
    run_to_done(100);
    chk("stall_total", la.size(), 4);

    // Zero-length pass
    clr_log();
    go(1'b0, 32'h7000, 16'd0, 64'h0);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b1);
    @(negedge clk);
    chk("len0_done_drop", done, 1'b0);
    chk("len0_idle", busy, 1'b0);
    chk("len0_acount", la.size(), 0);

    // start while busy is ignored
    clr_log();
    d_en = 1'b0;
    go(1'b0, 32'h4000, 16'd4, 64'h0);
    go(1'b0, 32'h5000, 16'd2, 64'h0);
    d_en = 1'b1;
    run_to_done(100);
    chk("ign_count", la.size(), 4);
    if (la.size() == 4) chk("ign_last_addr", la[3], 32'h4018);
    chk("ign_done_cnt", done_cnt, 1);

    // Reset mid-ISSUE with two outstanding
    clr_log();
    d_en = 1'b0;
    go(1'b0, 32'h6000, 16'd8, 64'h0);
    wait_acnt(2, 50);
    rst_n = 1'b0;
    #1;
    chk("rstmid_avalid", tl_o.a_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    d_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_drained", rspq.size(), 0);
    chk("late_errcnt", err_cnt, 16'h0);
    chk("late_err", err, 1'b0);
    chk("late_no_done", done_cnt, 0);
    chk("late_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
